// File: rtl/io_mmio_pkg.sv
// Shared register map and OUT_STATUS bit layout for the IO bus responder.
// Imported by io_mmio_responder and io_out_fifo.
package io_mmio_pkg;

    localparam logic [7:0] IO_LED        = 8'h00;
    localparam logic [7:0] IO_IN_STATUS  = 8'h04;
    localparam logic [7:0] IO_IN_DATA    = 8'h08;
    localparam logic [7:0] IO_OUT_STATUS = 8'h0C;
    localparam logic [7:0] IO_OUT_DATA   = 8'h10;
    localparam logic [7:0] IO_CYCLE      = 8'h14;

    localparam int OS_FULL    = 0;
    localparam int OS_EMPTY   = 1;
    localparam int OS_OVF     = 2;
    localparam int OS_CNT_LSB = 4;

endpackage

// File: rtl/io_out_fifo.sv
// Synchronous FIFO feeding the display output channel.
// Push while full is accepted only if a pop happens in the same cycle.
module io_out_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; the head mux hides stale words while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/io_mmio_responder.sv
// Memory-mapped IO responder: LED, switch-capture input, output FIFO, cycle counter.
// Define IO_CYCLE_CNT_EN to build the CYCLE register; otherwise 0x14 reads 0.
module io_mmio_responder
    import io_mmio_pkg::*;
#(
    parameter int OUT_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] io_addr,
    input  logic [31:0] io_dout,
    input  logic        io_we,
    input  logic        io_rd,
    output logic [31:0] io_din,
    input  logic [15:0] sw,
    input  logic        btn,
    output logic [15:0] led,
    output logic        in_vld,
    output logic [31:0] out_data,
    output logic        out_vld,
    input  logic        out_ack
);

    localparam int CW = $clog2(OUT_DEPTH) + 1;

    logic          hit;
    logic [7:0]    off;
    logic          wr_en;
    logic          rd_en;
    logic          in_rd;
    logic [15:0]   in_data;
    logic [2:0]    btn_sync;
    logic          btn_rise;
    logic          ovf;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [31:0]   out_status;
    logic [31:0]   cycle;

    assign hit   = (io_addr[15:8] == 8'h00);
    assign off   = io_addr[7:0];
    assign wr_en = io_we && hit;
    assign rd_en = io_rd && hit;
    assign in_rd = rd_en && (off == IO_IN_DATA);
    assign push  = wr_en && (off == IO_OUT_DATA);
    assign pop   = out_ack && out_vld;

    io_out_fifo #(
        .WIDTH (32),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (io_dout),
        .head  (out_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign out_vld = !empty;

    // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= '0;
            ovf <= 1'b0;
        end else begin
            if (wr_en && (off == IO_LED)) led <= io_dout[15:0];
            if (wr_en && (off == IO_OUT_STATUS) && io_dout[OS_OVF]) ovf <= 1'b0;
            else if (push && full && !pop) ovf <= 1'b1;
        end
    end

    // btn_sync[1] is the synchronized level, btn_sync[2] its previous value.
    assign btn_rise = btn_sync[1] && !btn_sync[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_sync <= '0;
            in_data  <= '0;
            in_vld   <= 1'b0;
        end else begin
            btn_sync <= {btn_sync[1:0], btn};
            if (btn_rise && (!in_vld || in_rd)) begin
                in_data <= sw;
                in_vld  <= 1'b1;
            end else if (in_rd) begin
                in_vld <= 1'b0;
            end
        end
    end

`ifdef IO_CYCLE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cycle <= '0;
        else     cycle <= cycle + 32'd1;
    end
`else
    assign cycle = '0;
`endif

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        out_status                     = '0;
        out_status[OS_FULL]            = full;
        out_status[OS_EMPTY]           = empty;
        out_status[OS_OVF]             = ovf;
        out_status[OS_CNT_LSB +: CW]   = count;
    end

    always_comb begin
        io_din = '0;
        if (rd_en) begin
            case (off)
                IO_LED:        io_din = {16'h0000, led};
                IO_IN_STATUS:  io_din = {31'h0, in_vld};
                IO_IN_DATA:    io_din = {16'h0000, in_data};
                IO_OUT_STATUS: io_din = out_status;
                IO_CYCLE:      io_din = cycle;
                default:       io_din = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_mmio_responder.sv
// Directed bench for io_mmio_responder: a vector table for the register/FIFO path
// plus hand sequences for the synchronizer, simultaneous push/pop, counter and async reset.
module tb_io_mmio_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] io_addr;
    logic [31:0] io_dout;
    logic        io_we;
    logic        io_rd;
    logic [31:0] io_din;
    logic [15:0] sw;
    logic        btn;
    logic [15:0] led;
    logic        in_vld;
    logic [31:0] out_data;
    logic        out_vld;
    logic        out_ack;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    io_mmio_responder #(.OUT_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .io_addr  (io_addr),
        .io_dout  (io_dout),
        .io_we    (io_we),
        .io_rd    (io_rd),
        .io_din   (io_din),
        .sw       (sw),
        .btn      (btn),
        .led      (led),
        .in_vld   (in_vld),
        .out_data (out_data),
        .out_vld  (out_vld),
        .out_ack  (out_ack)
    );

    typedef struct {
        logic        we;
        logic        rd;
        logic        ack;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_din;
        logic [15:0] exp_led;
        logic        exp_vld;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic rd, logic ack, logic [15:0] addr,
                                logic [31:0] wdata, logic [31:0] exp_din,
                                logic [15:0] exp_led, logic exp_vld, logic [31:0] exp_data);
        vec_t v;
        v.we = we; v.rd = rd; v.ack = ack; v.addr = addr; v.wdata = wdata;
        v.exp_din = exp_din; v.exp_led = exp_led; v.exp_vld = exp_vld; v.exp_data = exp_data;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // One bus cycle: drive at negedge, sample io_din mid-cycle, return 1 ns after the edge.
    task automatic step(input logic we, input logic rd, input logic ack, input logic [15:0] addr,
                        input logic [31:0] wdata, output logic [31:0] din);
        @(negedge clk);
        io_we = we; io_rd = rd; out_ack = ack; io_addr = addr; io_dout = wdata;
        #1 din = io_din;
        @(posedge clk);
        #1;
        io_we = 1'b0; io_rd = 1'b0; out_ack = 1'b0; io_addr = '0; io_dout = '0;
    endtask

    task automatic idle(input int n);
        logic [31:0] d;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, d);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [31:0] data);
        logic [31:0] d;
        step(1'b1, 1'b0, 1'b0, addr, data, d);
    endtask

    task automatic rd(input logic [15:0] addr, output logic [31:0] d);
        step(1'b0, 1'b1, 1'b0, addr, 32'h0, d);
    endtask

    task automatic ack1();
        logic [31:0] d;
        step(1'b0, 1'b0, 1'b1, 16'h0, 32'h0, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] c0;
        logic [31:0] c1;

        rst = 1'b1; io_addr = '0; io_dout = '0; io_we = 1'b0; io_rd = 1'b0;
        sw = '0; btn = 1'b0; out_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset led", {16'h0, led}, 32'h0);
        check("reset in_vld", {31'h0, in_vld}, 32'h0);
        check("reset out_vld", {31'h0, out_vld}, 32'h0);
        check("reset out_data", out_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        //            we    rd    ack   addr      wdata     exp_din   led      vld   data
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 32'hA5A5, 32'h0,    16'hA5A5, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0000, 32'h0,    32'hA5A5, 16'hA5A5, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0000, 32'h1111, 32'hA5A5, 16'h1111, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0100, 32'hFFFF, 32'h0,    16'h1111, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0004, 32'h0,    32'h0,    16'h1111, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'h000C, 32'h0,    32'h2,    16'h1111, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0010, 32'h1,    32'h0,    16'h1111, 1'b1, 32'h1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0010, 32'h2,    32'h0,    16'h1111, 1'b1, 32'h1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0010, 32'h3,    32'h0,    16'h1111, 1'b1, 32'h1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0010, 32'h4,    32'h0,    16'h1111, 1'b1, 32'h1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0010, 32'h5,    32'h0,    16'h1111, 1'b1, 32'h1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'h000C, 32'h0,    32'h45,   16'h1111, 1'b1, 32'h1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0018, 32'h0,    32'h0,    16'h1111, 1'b1, 32'h1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0000, 32'h0,    32'h0,    16'h1111, 1'b1, 32'h2));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0000, 32'h0,    32'h0,    16'h1111, 1'b1, 32'h3));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0000, 32'h0,    32'h0,    16'h1111, 1'b1, 32'h4));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0000, 32'h0,    32'h0,    16'h1111, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'h000C, 32'h0,    32'h6,    16'h1111, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 16'h000C, 32'h4,    32'h0,    16'h1111, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'h000C, 32'h0,    32'h2,    16'h1111, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0000, 32'h0,    32'h0,    16'h1111, 1'b0, 32'h0));

        foreach (vecs[i]) begin
            step(vecs[i].we, vecs[i].rd, vecs[i].ack, vecs[i].addr, vecs[i].wdata, d);
            check($sformatf("vec%0d io_din", i), d, vecs[i].exp_din);
            check($sformatf("vec%0d led", i), {16'h0, led}, {16'h0, vecs[i].exp_led});
            check($sformatf("vec%0d out_vld", i), {31'h0, out_vld}, {31'h0, vecs[i].exp_vld});
            check($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_data);
        end

        // Input channel: capture lands after the third edge.
        sw = 16'h1234; btn = 1'b1;
        idle(1); check("sync edge1 in_vld", {31'h0, in_vld}, 32'h0);
        idle(1); check("sync edge2 in_vld", {31'h0, in_vld}, 32'h0);
        idle(1); check("sync edge3 in_vld", {31'h0, in_vld}, 32'h1);
        rd(16'h0004, d); check("in_status", d, 32'h1);

        btn = 1'b0; idle(3);
        sw = 16'h5678; btn = 1'b1; idle(3);
        check("dropped edge in_vld", {31'h0, in_vld}, 32'h1);
        rd(16'h0008, d); check("in_data kept", d, 32'h1234);
        check("in_vld cleared", {31'h0, in_vld}, 32'h0);

        btn = 1'b0; idle(3);
        sw = 16'h0C0C; btn = 1'b1; idle(3);
        check("recapture in_vld", {31'h0, in_vld}, 32'h1);
        btn = 1'b0; idle(3);
        sw = 16'hBEEF; btn = 1'b1; idle(2);
        rd(16'h0008, d); check("edge+read old word", d, 32'h0C0C);
        check("edge+read in_vld", {31'h0, in_vld}, 32'h1);
        rd(16'h0008, d); check("edge+read new word", d, 32'hBEEF);
        check("edge+read cleared", {31'h0, in_vld}, 32'h0);
        btn = 1'b0;

        // Full FIFO with simultaneous push and pop.
        for (int k = 5; k <= 8; k++) wr(16'h0010, 32'(k));
        rd(16'h000C, d); check("full status", d, 32'h41);
        step(1'b1, 1'b0, 1'b1, 16'h0010, 32'h9, d);
        check("full push+pop head", out_data, 32'h6);
        rd(16'h000C, d); check("full push+pop status", d, 32'h41);
        ack1(); check("drain 7", out_data, 32'h7);
        ack1(); check("drain 8", out_data, 32'h8);
        ack1(); check("drain 9 last", out_data, 32'h9);
        ack1(); check("drained out_vld", {31'h0, out_vld}, 32'h0);

        // Empty FIFO with simultaneous push and pop: pop ignored.
        step(1'b1, 1'b0, 1'b1, 16'h0010, 32'hAA, d);
        check("empty push+pop head", out_data, 32'hAA);
        rd(16'h000C, d); check("empty push+pop status", d, 32'h10);
        ack1(); check("empty push+pop drained", {31'h0, out_vld}, 32'h0);

        // Cycle counter: two reads ten edges apart.
        rd(16'h0014, c0);
        idle(9);
        rd(16'h0014, c1);
`ifdef IO_CYCLE_CNT_EN
        check("cycle delta", c1 - c0, 32'd10);
`else
        check("cycle read0", c0, 32'h0);
        check("cycle read1", c1, 32'h0);
`endif

        // Asynchronous reset mid-transfer.
        for (int k = 1; k <= 3; k++) wr(16'h0010, 32'(k));
        idle(3);
        sw = 16'h7777; btn = 1'b1; idle(3);
        check("pre-reset out_vld", {31'h0, out_vld}, 32'h1);
        check("pre-reset in_vld", {31'h0, in_vld}, 32'h1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async rst out_vld", {31'h0, out_vld}, 32'h0);
        check("async rst in_vld", {31'h0, in_vld}, 32'h0);
        check("async rst out_data", out_data, 32'h0);
        check("async rst led", {16'h0, led}, 32'h0);
        btn = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rd(16'h000C, d); check("post-reset status", d, 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/io_mmio_responder.md
# io_mmio_responder

Responder end of the CPU IO bus: decodes the pipeline CPU's memory-mapped `io_addr`/`io_we`/`io_rd` accesses and serves the user-facing I/O registers, namely LEDs, a switch-capture input channel with valid handshake, a buffered output channel toward the display, and a free-running cycle counter. It sits between `Pipeline_CPU`'s IO_BUS and the board I/O logic, in the position the PDU's IO port occupies on the responder side.

## Interface
- `OUT_DEPTH`, default 4: output FIFO entries; power of two, 2 to 16.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous and active-high.
- `io_addr` in 16: byte address. Only bits [7:0] are decoded, and bits [15:8] must be 0 for a hit.
- `io_dout` in 32: CPU write data.
- `io_we` in 1: write strobe. Acts on the rising clock edge.
- `io_rd` in 1: read strobe. Side effects act on the rising clock edge.
- `io_din` out 32: read data to the CPU.
- `sw` in 16: switches, asynchronous.
- `btn` in 1: capture button, asynchronous and already debounced.
- `led` out 16: LED register.
- `in_vld` out 1: input word pending.
- `out_data` out 32: FIFO head word.
- `out_vld` out 1: FIFO not empty.
- `out_ack` in 1: consumer pops the head word.

## Operation
Register map (offsets):
- 0x00 LED (R/W): holds `io_dout[15:0]`. Reads return the value zero-extended.
- 0x04 IN_STATUS (R): bit0 = `in_vld`.
- 0x08 IN_DATA (R): returns the captured switch word, zero-extended. A read clears `in_vld`.
- 0x0C OUT_STATUS (R/W):
  - bit0 full, bit1 empty, bit2 overflow (sticky), bits[8:4] count.
  - Writing with bit2=1 clears overflow.
- 0x10 OUT_DATA (W): pushes `io_dout`. When the FIFO is full the push is dropped and overflow is set.
- 0x14 CYCLE (R): 32-bit cycle counter.
- Unmapped addresses and writes to read-only registers are ignored. Unmapped reads return 0.

Input channel:
- `btn` passes through a 2-flop synchronizer and then a rising-edge detect.
- An edge while `in_vld`=0 latches `sw` into IN_DATA and sets `in_vld`.
- An edge while `in_vld`=1 is dropped, and IN_DATA is kept.
- An edge in the same cycle as an IN_DATA read: the read returns the old word, the new word is captured, and `in_vld` stays 1.

Output channel:
- The FIFO has `OUT_DEPTH` entries.
- `out_data` shows the head word, or 0 when empty.
- The head is popped on a clock edge where `out_ack` && `out_vld`. `out_ack` while empty is ignored.
- Push and pop in the same cycle:
  - When full: both are accepted, count is unchanged, and overflow is not set.
  - When empty: the push is accepted and the pop is ignored.
- Pointers wrap modulo `OUT_DEPTH`.
- The cycle counter increments every cycle and wraps from 0xFFFFFFFF to 0.

## Timing
- `io_din` is combinational from `io_addr` while `io_rd`=1, and is 0 when `io_rd`=0. A read completes in the same cycle, with zero wait states.
- Write effects are visible on the cycle after the strobed edge.
- `btn` rising at edge N-0 causes `in_vld` to assert after edge 3.
- `out_vld` rises one cycle after the first push, and falls one cycle after the final pop.
- If `io_we` and `io_rd` are both high in one cycle, both are serviced. A read of a register returns its pre-write value.
- Reset values:
  - `led`, IN_DATA, `in_vld`, overflow, CYCLE and the synchronizer flops are all 0.
  - The FIFO is empty, with `out_vld`=0 and `out_data`=0.
- Asserting `rst` mid-transfer discards all FIFO contents and any pending input immediately, asynchronously.

## Configuration
- `IO_CYCLE_CNT_EN` defined: the CYCLE register and its counter are present.
- Undefined: the counter logic is removed, and reads of 0x14 return 0.

## Structure
- Package `io_mmio_pkg`: register offset constants (`IO_LED`, `IO_IN_STATUS`, `IO_IN_DATA`, `IO_OUT_STATUS`, `IO_OUT_DATA`, `IO_CYCLE`) and OUT_STATUS bit positions.
- Sub-module `io_out_fifo`: synchronous FIFO parameterized by width and depth, with push, pop, full, empty, count and head outputs.

## Test plan
- Reset, write 0x0000A5A5 to 0x00, then read 0x00: `led`=0xA5A5 on the next cycle, and the read returns 0x0000A5A5.
- `sw`=0x1234, pulse `btn`:
  - `in_vld`=1 after edge 3, and 0x04 reads 1.
  - Reading 0x08 returns 0x00001234, and `in_vld`=0 on the next cycle.
  - A second edge with `sw`=0x5678 while `in_vld`=1 leaves IN_DATA at 0x1234.
- With `OUT_DEPTH`=4:
  - Push 1 through 5 with `out_ack`=0: 0x0C reads full=1, count=4, overflow=1.
  - Pop four words: they come out as 1, 2, 3, 4, then `out_vld`=0.
  - Write 0x4 to 0x0C: overflow clears.
- Full FIFO with a simultaneous push of 9 and `out_ack`: count stays 4, overflow stays 0, and 9 drains last.
- Read 0x14 on two cycles 10 apart: the values differ by 10. With the macro undefined, both reads return 0.
- Assert `rst` with 3 FIFO entries and `in_vld`=1: `out_vld`=0 and `in_vld`=0 immediately, without waiting for a clock edge.
